// File: rtl/pcie_write_arbiter.sv
// rtl/pcie_write_arbiter.sv - round-robin arbiter sharing the PCIe message-RAM write engine
//
// Latches one DW-bit message from the granted requester and hands it to the
// write engine with a single-cycle enable, then waits for the engine to drop
// and re-raise ready before the next grant.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester message pending (level)
//   req_data     requester i message at [i*DW +: DW]
//   req_ack      one-hot pulse: message of requester i has been latched
//   wr_data      message to the write engine
//   wr_enable    single-cycle issue strobe to the write engine
//   wr_ready     write engine idle
//   grant_id     index of the last granted requester
//   busy         high whenever the FSM is not idle
//   timeout_err  sticky engine-timeout flag
//   msg_count    completed messages, wraps

module pcie_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 128,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [DW-1:0]           wr_data,
  output logic                    wr_enable,
  input  logic                    wr_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [CNTW-1:0]         msg_count
);

  localparam int             IDW    = $clog2(NREQ);
  localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLIM   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);
  localparam bit             TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [TW-1:0]   tmo_cnt, tmo_d;
  logic [NREQ-1:0] ack_d;
  logic [DW-1:0]   data_d;
  logic            en_d;
  logic [IDW-1:0]  grant_d;
  logic            busy_d;
  logic            err_d;
  logic [CNTW-1:0] cnt_d;

  logic [DW-1:0] req_word [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*DW +: DW];
  end

  // Round-robin search starting one past the last grant, wrapping at NREQ.
  logic           found;
  logic [IDW-1:0] pick;
  logic [IDW:0]   probe;

  always_comb begin
    found = 1'b0;
    pick  = grant_id;
    probe = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe = {1'b0, grant_id} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) begin
        probe = probe - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[probe[IDW-1:0]]) begin
        found = 1'b1;
        pick  = probe[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      req_ack     <= '0;
      wr_data     <= '0;
      wr_enable   <= 1'b0;
      grant_id    <= LAST;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      msg_count   <= '0;
    end else begin
      state       <= state_d;
      tmo_cnt     <= tmo_d;
      req_ack     <= ack_d;
      wr_data     <= data_d;
      wr_enable   <= en_d;
      grant_id    <= grant_d;
      busy        <= busy_d;
      timeout_err <= err_d;
      msg_count   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    tmo_d   = tmo_cnt;
    ack_d   = '0;
    data_d  = wr_data;
    en_d    = 1'b0;
    grant_d = grant_id;
    err_d   = timeout_err;
    cnt_d   = msg_count;

    case (state)
      IDLE: begin
        // Only grant while the engine is idle so the ack never runs ahead of it.
        if (found && wr_ready) begin
          data_d       = req_word[pick];
          grant_d      = pick;
          ack_d[pick]  = 1'b1;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        // The registered enable is visible in the first WAIT_LO cycle, which is
        // the engine's capture cycle.
        if (wr_ready) begin
          en_d    = 1'b1;
          tmo_d   = '0;
          state_d = WAIT_LO;
        end
      end

      WAIT_LO: begin
        tmo_d = tmo_cnt + 1'b1;
        if (!wr_ready) begin
          state_d = WAIT_HI;
        end else if (TMO_EN && tmo_cnt == TLIM) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WAIT_HI: begin
        tmo_d = tmo_cnt + 1'b1;
        if (wr_ready) begin
          cnt_d   = msg_count + 1'b1;
          state_d = IDLE;
        end else if (TMO_EN && tmo_cnt == TLIM) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_pcie_write_arbiter.sv
// tb/tb_pcie_write_arbiter.sv - scoreboard bench for pcie_write_arbiter

module tb_pcie_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 128;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic [DW-1:0]      wr_data;
  logic               wr_enable;
  logic               wr_ready;
  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_err;
  logic [3:0]         msg_count;

  pcie_write_arbiter #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(16), .CNTW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
    .wr_data(wr_data), .wr_enable(wr_enable), .wr_ready(wr_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .msg_count(msg_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write engine model: idle with ready=1, drops ready after a capture for
  // eng_len cycles (random 1..6 when eng_len==0), or until eng_hang clears.
  logic eng_rdy;
  logic hold_low;
  logic eng_hang;
  int   eng_len;
  assign wr_ready = eng_rdy & ~hold_low;

  initial begin
    logic cap;
    int   n;
    eng_rdy = 1'b1;
    forever begin
      @(negedge clk);
      cap = rst_n && wr_enable && wr_ready;
      if (cap) begin
        @(posedge clk);
        #1 eng_rdy = 1'b0;
        n = (eng_len > 0) ? eng_len : int'($urandom_range(1, 6));
        repeat (n) @(posedge clk);
        while (eng_hang) @(posedge clk);
        #1 eng_rdy = 1'b1;
      end
    end
  end

  // Requesters: each holds a FIFO of messages and presents its head while non-empty.
  logic [127:0] rmem [NREQ][16];
  int rhead [NREQ];
  int rtail [NREQ];

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (rhead[i] < rtail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = rmem[i][rhead[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input logic [127:0] d);
    if (rhead[r] == rtail[r]) begin
      rhead[r] = 0;
      rtail[r] = 0;
    end
    rmem[r][rtail[r]] = d;
    rtail[r]++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_ack[i] && rhead[i] < rtail[i]) rhead[i]++;
        end
        present();
      end
    end
  end

  // Reference model: plain round-robin over requesters that still hold messages.
  typedef struct {
    int           id;
    logic [127:0] d;
  } exp_t;

  int   ack_q [$];
  exp_t en_q  [$];
  int   mptr;
  int   exp_cnt;

  task automatic commit(output int total);
    int   cnt [NREQ];
    int   pos [NREQ];
    int   r;
    exp_t e;
    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = rhead[i];
      cnt[i] = rtail[i] - rhead[i];
      total += cnt[i];
    end
    for (int m = 0; m < total; m++) begin
      r = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (r < 0 && cnt[(mptr + k) % NREQ] > 0) r = (mptr + k) % NREQ;
      end
      ack_q.push_back(r);
      e.id = r;
      e.d  = rmem[r][pos[r]];
      en_q.push_back(e);
      pos[r]++;
      cnt[r]--;
      mptr = r;
    end
    present();
  endtask

  // Monitor / scoreboard.
  initial begin
    int   a;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_ack != '0) begin
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 128'(req_ack), 128'(0));
          end else begin
            a = ack_q.pop_front();
            check("ack_onehot", 128'(req_ack), 128'(4'b0001 << a));
          end
        end
        if (wr_enable) begin
          if (en_q.size() == 0) begin
            check("enable_unexpected", 128'(wr_enable), 128'(0));
          end else begin
            e = en_q.pop_front();
            check("enable_grant_id", 128'(grant_id), 128'(e.id));
            check("enable_wr_data", wr_data, e.d);
          end
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (ack_q.size() == 0 && en_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 128'(ok), 128'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ack"},     128'(req_ack),     128'(0));
    check({tag, "_wr_enable"},   128'(wr_enable),   128'(0));
    check({tag, "_wr_data"},     wr_data,           128'(0));
    check({tag, "_grant_id"},    128'(grant_id),    128'(3));
    check({tag, "_busy"},        128'(busy),        128'(0));
    check({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
    check({tag, "_msg_count"},   128'(msg_count),   128'(0));
  endtask

  task automatic clear_requesters();
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    present();
  endtask

  task automatic one_message(input int r);
    int n;
    load(r, {$urandom, $urandom, $urandom, $urandom});
    commit(n);
    wait_drain("single_drain");
    exp_cnt += n;
  endtask

  initial begin
    int n;
    logic found;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    hold_low  = 1'b0;
    eng_hang  = 1'b0;
    eng_len   = 0;
    mptr      = NREQ - 1;
    exp_cnt   = 0;
    clear_requesters();

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single message: ack, then enable one cycle later carrying the data.
    load(0, {4{32'hA5A5A5A5}});
    commit(n);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ack != '0) break;
    end
    check("t1_ack", 128'(req_ack), 128'(4'b0001));
    @(negedge clk);
    check("t1_enable", 128'(wr_enable), 128'(1));
    check("t1_data", wr_data, {4{32'hA5A5A5A5}});
    @(negedge clk);
    check("t1_enable_pulse", 128'(wr_enable), 128'(0));
    wait_drain("t1_drain");
    exp_cnt += n;
    check("t1_count", 128'(msg_count), 128'(exp_cnt % 16));

    // Engine never returns to ready: timeout after 16 cycles in WAIT_*.
    eng_hang = 1'b1;
    load(2, {$urandom, $urandom, $urandom, $urandom});
    commit(n);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_enable) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_enable_seen", 128'(found), 128'(1));
    repeat (15) @(negedge clk);
    check("t4_err_before", 128'(timeout_err), 128'(0));
    check("t4_busy_before", 128'(busy), 128'(1));
    @(negedge clk);
    check("t4_err_after", 128'(timeout_err), 128'(1));
    check("t4_idle_after", 128'(busy), 128'(0));
    check("t4_count_kept", 128'(msg_count), 128'(exp_cnt % 16));
    eng_hang = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 128'(timeout_err), 128'(1));

    // Reset asserted mid-transfer in WAIT_HI clears outputs without a clock edge.
    eng_hang = 1'b1;
    load(1, {$urandom, $urandom, $urandom, $urandom});
    commit(n);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_enable) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_enable_seen", 128'(found), 128'(1));
    repeat (2) @(negedge clk);
    check("t5_busy_pre", 128'(busy), 128'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    ack_q.delete();
    en_q.delete();
    clear_requesters();
    mptr     = NREQ - 1;
    exp_cnt  = 0;
    eng_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four requesting with a 6-cycle engine: grants 0,1,2,3,0.
    eng_len = 6;
    load(0, {$urandom, $urandom, $urandom, $urandom});
    load(0, {$urandom, $urandom, $urandom, $urandom});
    load(1, {$urandom, $urandom, $urandom, $urandom});
    load(2, {$urandom, $urandom, $urandom, $urandom});
    load(3, {$urandom, $urandom, $urandom, $urandom});
    commit(n);
    wait_drain("t2_drain");
    exp_cnt += n;
    check("t2_count", 128'(msg_count), 128'(exp_cnt % 16));
    eng_len = 0;

    // Engine not ready while idle: no ack and no enable until it is.
    hold_low = 1'b1;
    load(1, {$urandom, $urandom, $urandom, $urandom});
    commit(n);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t3_hold_quiet", 128'({req_ack, wr_enable}), 128'(0));
    end
    hold_low = 1'b0;
    wait_drain("t3_drain");
    exp_cnt += n;
    check("t3_count", 128'(msg_count), 128'(exp_cnt % 16));

    // Randomised batches.
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r < NREQ; r++) begin
        int k;
        k = int'($urandom_range(0, 3));
        for (int j = 0; j < k; j++) load(r, {$urandom, $urandom, $urandom, $urandom});
      end
      commit(n);
      wait_drain("batch_drain");
      exp_cnt += n;
      check("batch_count", 128'(msg_count), 128'(exp_cnt % 16));
    end

    // Counter wrap.
    while (exp_cnt % 16 != 15) one_message(int'($urandom_range(0, 3)));
    check("wrap_pre", 128'(msg_count), 128'(15));
    one_message(int'($urandom_range(0, 3)));
    check("wrap_post", 128'(msg_count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
